// File: rtl/compr_pkg.sv
// Shared types and constants for the activation compression path (encoder and decoder).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package compr_pkg;

  localparam int DATA_W  = 8;
  localparam int RUN_W   = 4;
  localparam int CNT_W   = 16;
  localparam int RUN_MAX = (1 << RUN_W) - 1;

  // One encoded token: run of zero words that precede data, plus tile-close flag.
  typedef struct packed {
    logic [RUN_W-1:0]  run;
    logic [DATA_W-1:0] data;
    logic              last;
  } rle_token_t;

  // Largest run a field of the given width can hold.
  function automatic int unsigned run_max_of(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/zero_rle_encoder_register.sv
// Generic enabled register with asynchronous active-low reset to a fixed value.
// Latency: 1 cycle from d/we to q.
// Backpressure: none; loads whenever we is high.
module register #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold state unless written; reset value applied asynchronously.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      q <= RST_VAL;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/zero_rle_encoder.sv
// Zero run-length encoder: turns a word stream into (run, value, last) tokens.
// Latency: 1 cycle from accepted input word to token on out_*.
// Backpressure: in_ready = !out_valid | out_ready; token held stable while stalled.
module zero_rle_encoder
  import compr_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int RUN_WIDTH  = RUN_W,
  parameter int CNT_WIDTH  = CNT_W
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RUN_WIDTH-1:0]  out_run,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  token_cnt
);

  localparam logic [RUN_WIDTH-1:0] RUN_LIMIT = RUN_WIDTH'(run_max_of(RUN_WIDTH));

  logic                  in_fire;
  logic                  out_fire;
  logic                  emit;
  logic                  load;
  logic [RUN_WIDTH-1:0]  run_q;
  logic [RUN_WIDTH-1:0]  run_eff;
  logic [RUN_WIDTH-1:0]  run_d;
  logic                  valid_we;
  logic                  valid_d;
  logic                  cnt_we;
  logic [CNT_WIDTH-1:0]  cnt_d;

  // Accept a new word whenever the output slot is empty or being drained now.
  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Token decision: last and non-zero words always emit; a zero emits only
  // when the run is saturated (that token covers RUN_MAX+1 zero words).
  // A clr in the same cycle discards pending zeros, so the word sees run 0.
  always_comb begin
    run_eff = clr ? '0 : run_q;
    emit    = in_last || (in_data != '0) || (run_eff == RUN_LIMIT);
    load    = in_fire && emit;
  end

  // Next run count: clr wins, then reset on emit, else count one more zero.
  always_comb begin
    run_d = run_q;
    if (clr) begin
      run_d = '0;
    end else if (in_fire) begin
      run_d = emit ? '0 : run_q + RUN_WIDTH'(1);
    end
  end

  // out_valid: set on load, cleared when drained without a replacement.
  always_comb begin
    valid_we = load || out_fire;
    valid_d  = load;
  end

  // Token counter: clr forces zero, otherwise count every delivered token.
  always_comb begin
    cnt_we = clr || out_fire;
    cnt_d  = clr ? '0 : token_cnt + CNT_WIDTH'(1);
  end

  register #(.WIDTH(RUN_WIDTH)) u_run_cnt (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .we        (1'b1),
    .d         (run_d),
    .q         (run_q)
  );

  register #(.WIDTH(1)) u_out_valid (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .we        (valid_we),
    .d         (valid_d),
    .q         (out_valid)
  );

  register #(.WIDTH(RUN_WIDTH)) u_out_run (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .we        (load),
    .d         (run_eff),
    .q         (out_run)
  );

  register #(.WIDTH(DATA_WIDTH)) u_out_data (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .we        (load),
    .d         (in_data),
    .q         (out_data)
  );

  register #(.WIDTH(1)) u_out_last (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .we        (load),
    .d         (in_last),
    .q         (out_last)
  );

  register #(.WIDTH(CNT_WIDTH)) u_token_cnt (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .we        (cnt_we),
    .d         (cnt_d),
    .q         (token_cnt)
  );

endmodule

// File: tb/tb_zero_rle_encoder.sv
// Directed bench for zero_rle_encoder with hand-computed token expectations.
// Latency: inputs driven #1 after a rising edge, outputs sampled #1 after the next.
// Backpressure: out_ready driven directly to exercise stalls and replacement.
module tb_zero_rle_encoder;

  logic        clk;
  logic        arst_n_in;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_run;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] token_cnt;

  int checks = 0;
  int errors = 0;

  zero_rle_encoder #(.DATA_WIDTH(8), .RUN_WIDTH(4), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_run   (out_run),
    .out_data  (out_data),
    .out_last  (out_last),
    .token_cnt (token_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_tok(input string tag, input int r, input int d, input int l);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_run"},   32'(out_run),   32'(r));
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_last"},  32'(out_last),  32'(l));
  endtask

  // Present one word for exactly one rising edge, then sample.
  task automatic drive(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n_in = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_run",   32'(out_run),   32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_cnt",   32'(token_cnt), 32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    arst_n_in = 1'b1;
    idle();

    // T1: 0,0,5,7(last) -> (2,5,0), (0,7,1)
    drive(8'd0, 1'b0);
    chk("t1_z0_valid", 32'(out_valid), 32'd0);
    drive(8'd0, 1'b0);
    chk("t1_z1_valid", 32'(out_valid), 32'd0);
    drive(8'd5, 1'b0);
    chk_tok("t1_tok5", 2, 5, 0);
    drive(8'd7, 1'b1);
    chk_tok("t1_tok7", 0, 7, 1);
    chk("t1_cnt1", 32'(token_cnt), 32'd1);
    idle();
    chk("t1_drain_valid", 32'(out_valid), 32'd0);
    chk("t1_cnt2", 32'(token_cnt), 32'd2);

    // T2: 16 zeros then 3(last) -> (15,0,0) covering 16 zeros, then (0,3,1)
    for (int i = 0; i < 15; i++) drive(8'd0, 1'b0);
    chk("t2_z15_valid", 32'(out_valid), 32'd0);
    drive(8'd0, 1'b0);
    chk_tok("t2_sat", 15, 0, 0);
    drive(8'd3, 1'b1);
    chk_tok("t2_tok3", 0, 3, 1);
    chk("t2_cnt", 32'(token_cnt), 32'd3);

    // T3: stall (0,3,1) for 4 cycles with word 6 waiting, then release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd6;
    in_last   = 1'b0;
    #1;
    chk("t3_ready_lo", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("t3_stall_ready", 32'(in_ready), 32'd0);
      chk_tok("t3_stall", 0, 3, 1);
    end
    chk("t3_stall_cnt", 32'(token_cnt), 32'd3);
    out_ready = 1'b1;
    #1;
    chk("t3_ready_hi", 32'(in_ready), 32'd1);
    idle();
    in_valid = 1'b0;
    in_data  = '0;
    chk_tok("t3_tok6", 0, 6, 0);
    chk("t3_cnt4", 32'(token_cnt), 32'd4);
    idle();
    chk("t3_drain_valid", 32'(out_valid), 32'd0);
    chk("t3_cnt5", 32'(token_cnt), 32'd5);

    // T4: lone zero with last -> (0,0,1); next tile starts at run 0
    drive(8'd0, 1'b1);
    chk_tok("t4_zlast", 0, 0, 1);
    drive(8'd8, 1'b0);
    chk_tok("t4_tok8", 0, 8, 0);
    chk("t4_cnt6", 32'(token_cnt), 32'd6);
    idle();
    chk("t4_cnt7", 32'(token_cnt), 32'd7);

    // T5: 3 zeros, then clr together with 9 -> (0,9,0), counter cleared
    for (int i = 0; i < 3; i++) drive(8'd0, 1'b0);
    chk("t5_z_valid", 32'(out_valid), 32'd0);
    clr = 1'b1;
    drive(8'd9, 1'b0);
    clr = 1'b0;
    chk_tok("t5_tok9", 0, 9, 0);
    chk("t5_cnt0", 32'(token_cnt), 32'd0);
    idle();
    chk("t5_cnt1", 32'(token_cnt), 32'd1);

    // T6a: reset with an undelivered token
    out_ready = 1'b0;
    drive(8'd3, 1'b0);
    chk_tok("t6_pend", 0, 3, 0);
    #1 arst_n_in = 1'b0;
    #1;
    chk("t6a_valid", 32'(out_valid), 32'd0);
    chk("t6a_data",  32'(out_data),  32'd0);
    chk("t6a_cnt",   32'(token_cnt), 32'd0);
    @(negedge clk);
    arst_n_in = 1'b1;
    out_ready = 1'b1;
    idle();
    chk("t6a_post_valid", 32'(out_valid), 32'd0);

    // T6b: reset with run at 6, then 4 -> (0,4,0)
    for (int i = 0; i < 6; i++) drive(8'd0, 1'b0);
    #1 arst_n_in = 1'b0;
    #1;
    chk("t6b_valid", 32'(out_valid), 32'd0);
    chk("t6b_run",   32'(out_run),   32'd0);
    chk("t6b_last",  32'(out_last),  32'd0);
    @(negedge clk);
    arst_n_in = 1'b1;
    idle();
    idle();
    chk("t6b_post_valid", 32'(out_valid), 32'd0);
    drive(8'd4, 1'b0);
    chk_tok("t6_tok4", 0, 4, 0);
    chk("t6_cnt0", 32'(token_cnt), 32'd0);
    idle();
    chk("t6_cnt1", 32'(token_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
